// File: rtl/baud_tick_scheduler_pkg.sv
// Shared FSM encoding and default parameters for the baud tick scheduler.
package baud_tick_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } sched_state_e;

    localparam int unsigned N_DIV_VAL       = 8;
    localparam int unsigned DEFAULT_DIV_VAL = 163;
    localparam int unsigned OVS_VAL         = 16;

endpackage

// File: rtl/baud_tick_scheduler_div_counter.sv
// Loadable-modulus divider counter: counts 0..modulus-1 while running, with
// a synchronous clear that wins over counting.
module baud_div_counter #(
    parameter int unsigned N_DIV = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_run,
    input  logic             i_clear,
    input  logic [N_DIV-1:0] i_modulus,
    output logic             o_wrap
);

    logic [N_DIV-1:0] count_q;
    logic [N_DIV-1:0] count_d;

    // ">=" keeps the counter bounded even if the modulus ever shrank under it.
    always_comb begin
        o_wrap  = i_run && (count_q >= (i_modulus - 1'b1));
        count_d = count_q;
        if (i_clear || o_wrap) begin
            count_d = '0;
        end else if (i_run) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/baud_tick_scheduler.sv
// Baud tick scheduler: programmable oversample divider with TX bit-boundary
// and RX mid-bit ticks, plus a glitch-free divisor update handshake.
module baud_tick_scheduler
    import baud_tick_scheduler_pkg::*;
#(
    parameter int unsigned N_DIV       = N_DIV_VAL,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_VAL,
    parameter int unsigned OVS         = OVS_VAL
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_cfg_valid,
    input  logic [N_DIV-1:0] i_cfg_div,
    output logic             o_cfg_ready,
    output logic             o_cfg_err,
    input  logic             i_rx_sync,
    output logic             o_os_tick,
    output logic             o_tx_bit_tick,
    output logic             o_rx_sample_tick,
    output logic [N_DIV-1:0] o_div
);

    localparam int unsigned PW = $clog2(OVS);

    sched_state_e     state_q, state_d;
    logic [N_DIV-1:0] div_q, div_d;
    logic [N_DIV-1:0] pend_div_q, pend_div_d;
    logic             err_q, err_d;
    logic [PW-1:0]    tx_phase_q, tx_phase_d;
    logic [PW-1:0]    rx_phase_q, rx_phase_d;

    logic active;
    logic sync_hit;
    logic xfer;
    logic cfg_good;
    logic cnt_wrap;
    logic cnt_clear;
    logic restart;

    assign active    = (state_q != ST_IDLE);
    assign sync_hit  = active && i_rx_sync;
    assign xfer      = i_cfg_valid && o_cfg_ready;
    assign cfg_good  = (i_cfg_div >= N_DIV'(2));
    assign cnt_clear = !active || !i_enable || sync_hit;
    assign restart   = cnt_wrap || sync_hit;

    baud_div_counter #(
        .N_DIV(N_DIV)
    ) u_div_counter (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_run    (active),
        .i_clear  (cnt_clear),
        .i_modulus(div_q),
        .o_wrap   (cnt_wrap)
    );

    // A realignment pulse swallows the tick that would have landed in its cycle.
    assign o_os_tick        = cnt_wrap && !i_rx_sync;
    assign o_tx_bit_tick    = o_os_tick && (tx_phase_q == PW'(OVS - 1));
    assign o_rx_sample_tick = o_os_tick && (rx_phase_q == PW'(OVS / 2 - 1));
    assign o_cfg_ready      = (state_q != ST_PEND);
    assign o_cfg_err        = err_q;
    assign o_div            = div_q;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        pend_div_d = pend_div_q;
        err_d      = xfer && !cfg_good;
        tx_phase_d = o_os_tick ? tx_phase_q + 1'b1 : tx_phase_q;
        rx_phase_d = sync_hit ? '0 : (o_os_tick ? rx_phase_q + 1'b1 : rx_phase_q);

        case (state_q)
            ST_IDLE: begin
                if (xfer && cfg_good) begin
                    div_d = i_cfg_div;
                end
                if (i_enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!i_enable) begin
                    state_d = ST_IDLE;
                    if (xfer && cfg_good) begin
                        div_d = i_cfg_div;
                    end
                end else if (xfer && cfg_good) begin
                    pend_div_d = i_cfg_div;
                    state_d    = ST_PEND;
                end
            end
            ST_PEND: begin
                // Swap only at a period boundary so no period mixes divisors.
                if (!i_enable || restart) begin
                    div_d      = pend_div_q;
                    pend_div_d = '0;
                    state_d    = i_enable ? ST_RUN : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!i_enable) begin
            tx_phase_d = '0;
            rx_phase_d = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            div_q      <= N_DIV'(DEFAULT_DIV);
            pend_div_q <= '0;
            err_q      <= 1'b0;
            tx_phase_q <= '0;
            rx_phase_q <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            pend_div_q <= pend_div_d;
            err_q      <= err_d;
            tx_phase_q <= tx_phase_d;
            rx_phase_q <= rx_phase_d;
        end
    end

endmodule

// File: tb/tb_baud_tick_scheduler.sv
// Self-checking bench for baud_tick_scheduler: directed scenarios plus
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_baud_tick_scheduler;

    localparam int OVS         = 16;
    localparam int DEFAULT_DIV = 163;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_enable;
    logic       i_cfg_valid;
    logic [7:0] i_cfg_div;
    logic       i_rx_sync;
    logic       o_cfg_ready;
    logic       o_cfg_err;
    logic       o_os_tick;
    logic       o_tx_bit_tick;
    logic       o_rx_sample_tick;
    logic [7:0] o_div;

    int checks   = 0;
    int failures = 0;

    logic [12:0] obs_v;
    logic [12:0] exp_v;
    logic [12:0] reset_v;

    // Behavioural model: running flag, divisor, pending divisor, cycles into
    // the current period, and oversample ticks since the TX/RX phase origin.
    bit m_run;
    bit m_has_pend;
    bit m_err;
    int m_div;
    int m_pend;
    int m_phase;
    int m_txn;
    int m_rxn;

    baud_tick_scheduler dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_enable        (i_enable),
        .i_cfg_valid     (i_cfg_valid),
        .i_cfg_div       (i_cfg_div),
        .o_cfg_ready     (o_cfg_ready),
        .o_cfg_err       (o_cfg_err),
        .i_rx_sync       (i_rx_sync),
        .o_os_tick       (o_os_tick),
        .o_tx_bit_tick   (o_tx_bit_tick),
        .o_rx_sample_tick(o_rx_sample_tick),
        .o_div           (o_div)
    );

    always #5 i_clk = ~i_clk;

    assign obs_v   = {o_cfg_ready, o_cfg_err, o_os_tick, o_tx_bit_tick, o_rx_sample_tick, o_div};
    assign reset_v = {1'b1, 1'b0, 3'b000, 8'(DEFAULT_DIV)};

    function automatic void model_reset();
        m_run      = 1'b0;
        m_has_pend = 1'b0;
        m_err      = 1'b0;
        m_div      = DEFAULT_DIV;
        m_pend     = 0;
        m_phase    = 0;
        m_txn      = 0;
        m_rxn      = 0;
    endfunction

    function automatic logic [12:0] model_expect();
        bit tick;
        tick = m_run && (m_phase == m_div - 1) && !i_rx_sync;
        return {!m_has_pend, m_err, tick,
                tick && (m_txn % OVS == OVS - 1),
                tick && (m_rxn % OVS == OVS / 2 - 1),
                8'(m_div)};
    endfunction

    function automatic void model_step();
        bit accept, good, tick, restart;
        accept = i_cfg_valid && !m_has_pend;
        good   = (i_cfg_div >= 2);
        tick   = m_run && (m_phase == m_div - 1) && !i_rx_sync;
        m_err  = accept && !good;
        if (!m_run) begin
            if (accept && good) m_div = i_cfg_div;
            m_run = i_enable;
        end else if (!i_enable) begin
            if (accept && good) m_div = i_cfg_div;
            else if (m_has_pend) m_div = m_pend;
            m_has_pend = 1'b0;
            m_run      = 1'b0;
            m_phase    = 0;
            m_txn      = 0;
            m_rxn      = 0;
        end else begin
            restart = (m_phase == m_div - 1) || i_rx_sync;
            if (tick) begin
                m_txn = (m_txn + 1) % OVS;
                m_rxn = (m_rxn + 1) % OVS;
            end
            if (i_rx_sync) m_rxn = 0;
            m_phase = restart ? 0 : m_phase + 1;
            if (restart && m_has_pend) begin
                m_div      = m_pend;
                m_has_pend = 1'b0;
            end
            if (accept && good) begin
                m_pend     = i_cfg_div;
                m_has_pend = 1'b1;
            end
        end
    endfunction

    task automatic drive(input bit en, input bit valid, input int cfg, input bit sync);
        i_enable    = en;
        i_cfg_valid = valid;
        i_cfg_div   = 8'(cfg);
        i_rx_sync   = sync;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        drive(1, 1, 5, 1);
        model_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            checks++;
            if (obs_v !== reset_v) begin
                failures++;
                $display("[TB] FAIL reset_outputs c=%0d got=%h exp=%h", c, obs_v, reset_v);
            end
            @(posedge i_clk);
            #1;
        end
        drive(0, 0, 0, 0);
        i_reset = 1'b0;
    endtask

    task automatic test_defaults();
        int first_os = -1;
        int first_tx = -1;
        int n_os     = 0;
        drive(1, 0, 0, 0);
        for (int c = 0; c < 2700; c++) begin
            @(negedge i_clk);
            exp_v = model_expect();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("[TB] FAIL defaults_cycle c=%0d got=%h exp=%h", c, obs_v, exp_v);
            end
            if (o_os_tick) begin
                n_os++;
                if (first_os < 0) first_os = c;
            end
            if (o_tx_bit_tick && first_tx < 0) first_tx = c;
            @(posedge i_clk);
            model_step();
            #1;
        end
        checks++;
        if (first_os !== 163) begin
            failures++;
            $display("[TB] FAIL defaults_first_os got=%0d exp=163", first_os);
        end
        checks++;
        if (first_tx !== 2608) begin
            failures++;
            $display("[TB] FAIL defaults_first_tx got=%0d exp=2608", first_tx);
        end
        checks++;
        if (n_os !== 16) begin
            failures++;
            $display("[TB] FAIL defaults_os_count got=%0d exp=16", n_os);
        end
    endtask

    task automatic test_div_change();
        int sent = -1;
        int t1   = -1;
        int t2   = -1;
        for (int c = 0; c < 300; c++) begin
            bit v;
            v = (sent < 0) && (m_phase == 50);
            drive(1, v, 10, 0);
            if (v) sent = c;
            @(negedge i_clk);
            exp_v = model_expect();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("[TB] FAIL div_change_cycle c=%0d got=%h exp=%h", c, obs_v, exp_v);
            end
            if (sent >= 0 && c == sent + 1) begin
                checks++;
                if (o_cfg_ready !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL div_change_ready got=%b exp=0", o_cfg_ready);
                end
            end
            if (sent >= 0 && c > sent && o_os_tick) begin
                if (t1 < 0) t1 = c - sent;
                else if (t2 < 0) t2 = c - sent;
            end
            @(posedge i_clk);
            model_step();
            #1;
        end
        checks++;
        if (t1 !== 112 || t2 !== 122) begin
            failures++;
            $display("[TB] FAIL div_change_ticks got=%0d,%0d exp=112,122", t1, t2);
        end
        checks++;
        if (o_div !== 8'd10) begin
            failures++;
            $display("[TB] FAIL div_change_div got=%0d exp=10", o_div);
        end
    endtask

    task automatic test_cfg_err();
        int n_err     = 0;
        int first_err = -1;
        for (int c = 0; c < 80; c++) begin
            drive(1, (c == 5) || (c == 40), (c == 5) ? 1 : 0, 0);
            @(negedge i_clk);
            exp_v = model_expect();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("[TB] FAIL cfg_err_cycle c=%0d got=%h exp=%h", c, obs_v, exp_v);
            end
            if (o_cfg_err) begin
                n_err++;
                if (first_err < 0) first_err = c;
            end
            @(posedge i_clk);
            model_step();
            #1;
        end
        checks++;
        if (n_err !== 2 || first_err !== 6) begin
            failures++;
            $display("[TB] FAIL cfg_err_pulses got=%0d@%0d exp=2@6", n_err, first_err);
        end
        checks++;
        if (o_div !== 8'd10) begin
            failures++;
            $display("[TB] FAIL cfg_err_div got=%0d exp=10", o_div);
        end
    endtask

    task automatic test_rx_sync();
        int s   = -1;
        int os1 = -1;
        int rx1 = -1;
        int rx2 = -1;
        bit tick_at_s = 1'b1;
        for (int c = 0; c < 400; c++) begin
            bit v;
            v = (s < 0) && (m_phase == 9) && (m_div == 10);
            drive(1, 0, 0, v);
            if (v) s = c;
            @(negedge i_clk);
            exp_v = model_expect();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("[TB] FAIL rx_sync_cycle c=%0d got=%h exp=%h", c, obs_v, exp_v);
            end
            if (c == s) tick_at_s = o_os_tick;
            if (s >= 0 && c > s) begin
                if (o_os_tick && os1 < 0) os1 = c - s;
                if (o_rx_sample_tick) begin
                    if (rx1 < 0) rx1 = c - s;
                    else if (rx2 < 0) rx2 = c - s;
                end
            end
            @(posedge i_clk);
            model_step();
            #1;
        end
        checks++;
        if (tick_at_s !== 1'b0 || os1 !== 10) begin
            failures++;
            $display("[TB] FAIL rx_sync_os got=%b,%0d exp=0,10", tick_at_s, os1);
        end
        checks++;
        if (rx1 !== 80 || rx2 !== 240) begin
            failures++;
            $display("[TB] FAIL rx_sync_sample got=%0d,%0d exp=80,240", rx1, rx2);
        end
        for (int c = 0; c < 600; c++) begin
            drive(1, 0, 0, ($urandom % 30) == 0);
            @(negedge i_clk);
            exp_v = model_expect();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("[TB] FAIL rx_sync_random c=%0d got=%h exp=%h", c, obs_v, exp_v);
            end
            @(posedge i_clk);
            model_step();
            #1;
        end
    endtask

    task automatic test_pend_disable();
        int sent       = -1;
        int reen       = -1;
        int first      = -1;
        int idle_ticks = 0;
        for (int c = 0; c < 120; c++) begin
            bit en, v;
            en = !(sent >= 0 && c > sent && c <= sent + 30);
            v  = (c == 3);
            drive(en, v, 20, 0);
            if (v) sent = c;
            if (en && sent >= 0 && c > sent + 30 && reen < 0) reen = c;
            @(negedge i_clk);
            exp_v = model_expect();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("[TB] FAIL pend_disable_cycle c=%0d got=%h exp=%h", c, obs_v, exp_v);
            end
            if (sent >= 0 && c >= sent + 2 && c <= sent + 30 && o_os_tick) idle_ticks++;
            if (sent >= 0 && c == sent + 20) begin
                checks++;
                if (o_div !== 8'd20 || o_cfg_ready !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL pend_disable_idle div=%0d ready=%b exp div=20 ready=1", o_div, o_cfg_ready);
                end
            end
            if (reen >= 0 && o_os_tick && first < 0) first = c - reen;
            @(posedge i_clk);
            model_step();
            #1;
        end
        checks++;
        if (idle_ticks !== 0) begin
            failures++;
            $display("[TB] FAIL pend_disable_idle_ticks got=%0d exp=0", idle_ticks);
        end
        checks++;
        if (first !== 20) begin
            failures++;
            $display("[TB] FAIL pend_disable_reenable got=%0d exp=20", first);
        end
    endtask

    task automatic test_reset_mid_pend();
        drive(1, 1, 30, 0);
        @(negedge i_clk);
        @(posedge i_clk);
        model_step();
        #1;
        drive(1, 0, 0, 0);
        @(negedge i_clk);
        checks++;
        if (o_cfg_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_pend_ready got=%b exp=0", o_cfg_ready);
        end
        i_reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (obs_v !== reset_v) begin
                failures++;
                $display("[TB] FAIL reset_pend_outputs c=%0d got=%h exp=%h", c, obs_v, reset_v);
            end
            @(posedge i_clk);
        end
        #1;
        i_reset = 1'b0;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge i_clk);
            exp_v = model_expect();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("[TB] FAIL reset_pend_cycle c=%0d got=%h exp=%h", c, obs_v, exp_v);
            end
            @(posedge i_clk);
            model_step();
            #1;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            drive(($urandom % 100) < 95, ($urandom % 8) == 0,
                  int'($urandom_range(0, 24)), ($urandom % 25) == 0);
            @(negedge i_clk);
            exp_v = model_expect();
            checks++;
            if (obs_v !== exp_v) begin
                failures++;
                $display("[TB] FAIL random_cycle c=%0d got=%h exp=%h", c, obs_v, exp_v);
            end
            @(posedge i_clk);
            model_step();
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        i_reset = 1'b1;
        drive(0, 0, 0, 0);
        @(posedge i_clk);
        #1;
        test_reset();
        test_defaults();
        test_div_change();
        test_cfg_err();
        test_rx_sync();
        test_pend_disable();
        test_reset_mid_pend();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
